// File: rtl/ams_pwm_pkg.sv
// Shared types and constants for the four-channel dithered PWM DAC.
// Build option: PWM_DITHER_EN enables the 16-bit per-frame dither pattern.
package ams_pwm_pkg;

    localparam int CFG_W    = 24;
    localparam int BASE_W   = 8;
    localparam int PAT_W    = 16;
    localparam int CNT_W    = 9;
    localparam int PIDX_W   = 4;
    localparam int NCH      = 4;

    localparam int BASE_MSB = 23;
    localparam int BASE_LSB = 16;
    localparam int PAT_MSB  = 15;
    localparam int PAT_LSB  = 0;

    // Default period length in clk cycles; legal range is 2..511.
    localparam int CCRE_DEF = 156;

    // Field order matches the register block's setpoint layout.
    typedef struct packed {
        logic [BASE_W-1:0] base;
        logic [PAT_W-1:0]  pat;
    } setpoint_t;

    // Nine-bit threshold so base 255 plus a dither bit reaches 256 without wrapping.
    function automatic logic [CNT_W-1:0] calc_thr(
        input logic [BASE_W-1:0] base,
        input logic              dither
    );
        return {1'b0, base} + {{(CNT_W-1){1'b0}}, dither};
    endfunction

endpackage

// File: rtl/ams_pwm_ch.sv
// One PWM channel: frame-aligned setpoint shadow, threshold compare and output flop.
// Build option: PWM_DITHER_EN keeps the dither-pattern shadow; otherwise only the base is stored.
module ams_pwm_ch
    import ams_pwm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  k_i,
    input  logic [PIDX_W-1:0] p_i,
    input  logic [CFG_W-1:0]  cfg_i,
    output logic              pwm_o
);

    setpoint_t         sp_s;
    logic [BASE_W-1:0] base_q;
    logic [BASE_W-1:0] base_d;
    logic              dither_s;
    logic [CNT_W-1:0]  thr_s;
    logic              pwm_q;
    logic              pwm_d;

    assign sp_s = setpoint_t'(cfg_i);

    // Base shadow: on the load edge the incoming setpoint bypasses the shadow so
    // the first cycle of the new frame already uses it.
    always_comb begin
        base_d = base_q;
        if (load_i) begin
            base_d = sp_s.base;
        end else begin
            base_d = base_q;
        end
    end

`ifdef PWM_DITHER_EN
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;

    // Pattern shadow, same load/bypass behaviour as the base.
    always_comb begin
        pat_d = pat_q;
        if (load_i) begin
            pat_d = sp_s.pat;
        end else begin
            pat_d = pat_q;
        end
    end

    // Pattern shadow register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pat_q <= {PAT_W{1'b0}};
        end else begin
            pat_q <= pat_d;
        end
    end

    assign dither_s = pat_d[p_i];
`else
    logic unused_pat_s;

    assign unused_pat_s = ^{sp_s.pat, p_i};
    assign dither_s     = 1'b0;
`endif

    // Compare the shared period counter against this channel's threshold.
    always_comb begin
        thr_s = calc_thr(base_d, dither_s);
        pwm_d = (k_i < thr_s);
    end

    // Base shadow and registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q <= {BASE_W{1'b0}};
            pwm_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/ams_pwm_dac.sv
// Four-channel dithered PWM DAC top: shared period/frame counters, frame strobe, channel array.
// Build option: PWM_DITHER_EN (passed through to ams_pwm_ch) enables the dither pattern.
module ams_pwm_dac
    import ams_pwm_pkg::*;
#(
    parameter int CCRE = CCRE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CFG_W-1:0] cfg_a_i,
    input  logic [CFG_W-1:0] cfg_b_i,
    input  logic [CFG_W-1:0] cfg_c_i,
    input  logic [CFG_W-1:0] cfg_d_i,
    output logic [NCH-1:0]   pwm_o,
    output logic             frame_o
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(CCRE - 1);

    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  k_d;
    logic [PIDX_W-1:0] p_q;
    logic [PIDX_W-1:0] p_d;
    logic              frame_q;
    logic              frame_d;
    logic              load_s;
    logic [CFG_W-1:0]  cfg_s [NCH];
    logic [NCH-1:0]    pwm_s;

    // Counters describe the output cycle being computed for the next edge, so
    // the (0,0) state is exactly the edge on which the shadows load.
    always_comb begin
        k_d     = k_q;
        p_d     = p_q;
        load_s  = (k_q == {CNT_W{1'b0}}) && (p_q == {PIDX_W{1'b0}});
        frame_d = load_s;
        if (k_q == K_LAST) begin
            k_d = {CNT_W{1'b0}};
            p_d = p_q + PIDX_W'(1);
        end else begin
            k_d = k_q + CNT_W'(1);
            p_d = p_q;
        end
    end

    // Period/frame counters and frame strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q     <= {CNT_W{1'b0}};
            p_q     <= {PIDX_W{1'b0}};
            frame_q <= 1'b0;
        end else begin
            k_q     <= k_d;
            p_q     <= p_d;
            frame_q <= frame_d;
        end
    end

    assign cfg_s[0] = cfg_a_i;
    assign cfg_s[1] = cfg_b_i;
    assign cfg_s[2] = cfg_c_i;
    assign cfg_s[3] = cfg_d_i;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ams_pwm_ch u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .load_i (load_s),
            .k_i    (k_q),
            .p_i    (p_q),
            .cfg_i  (cfg_s[gi]),
            .pwm_o  (pwm_s[gi])
        );
    end

    assign pwm_o   = pwm_s;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed self-checking bench for ams_pwm_dac with CCRE = 156.
// Expectations follow PWM_DITHER_EN when the bench is built with it.
module tb_ams_pwm_dac;

    localparam int CCRE = 156;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [23:0] cfg_a_i;
    logic [23:0] cfg_b_i;
    logic [23:0] cfg_c_i;
    logic [23:0] cfg_d_i;
    logic [3:0]  pwm_o;
    logic        frame_o;

    int checks_n = 0;
    int errors_n = 0;
    int tot_b;

    always #5 clk_i = ~clk_i;

    ams_pwm_dac #(.CCRE(CCRE)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cfg_a_i (cfg_a_i),
        .cfg_b_i (cfg_b_i),
        .cfg_c_i (cfg_c_i),
        .cfg_d_i (cfg_d_i),
        .pwm_o   (pwm_o),
        .frame_o (frame_o)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        checks_n++;
        if (act != exp) begin
            errors_n++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // High cycles expected in period p for a setpoint.
    function automatic int exp_hi(input logic [23:0] sp, input int p);
        int t;
        t = int'(sp[23:16]);
`ifdef PWM_DITHER_EN
        t = t + int'(sp[p]);
`endif
        if (t > CCRE) t = CCRE;
        return t;
    endfunction

    // Run one full frame starting at the cycle after its load edge; optionally
    // change the inputs at output cycle (chg_p, chg_k).
    task automatic run_frame(input string tag,
                             input logic [23:0] ea, input logic [23:0] eb,
                             input logic [23:0] ec, input logic [23:0] ed,
                             input int chg_p, input int chg_k,
                             input logic [23:0] na, input logic [23:0] nb,
                             input logic [23:0] nc, input logic [23:0] nd,
                             output int total_b);
        logic [23:0] e [4];
        int          cnt [4];
        int          extra;
        logic [3:0]  exp0;
        e       = '{ea, eb, ec, ed};
        extra   = 0;
        total_b = 0;
        for (int p = 0; p < 16; p++) begin
            for (int ch = 0; ch < 4; ch++) cnt[ch] = 0;
            for (int k = 0; k < CCRE; k++) begin
                @(negedge clk_i);
                if (p == 0 && k == 0) check_eq({tag, " frame_o"}, int'(frame_o), 1);
                else if (frame_o) extra++;
                if (k == 0) begin
                    for (int ch = 0; ch < 4; ch++) exp0[ch] = (exp_hi(e[ch], p) > 0);
                    check_eq($sformatf("%s p%0d k0 pwm", tag, p), int'(pwm_o), int'(exp0));
                end
                for (int ch = 0; ch < 4; ch++) cnt[ch] += int'(pwm_o[ch]);
                if (p == chg_p && k == chg_k) begin
                    cfg_a_i = na;
                    cfg_b_i = nb;
                    cfg_c_i = nc;
                    cfg_d_i = nd;
                end
            end
            for (int ch = 0; ch < 4; ch++)
                check_eq($sformatf("%s p%0d ch%0d high", tag, p, ch), cnt[ch], exp_hi(e[ch], p));
            total_b += cnt[1];
        end
        check_eq({tag, " extra frame_o"}, extra, 0);
    endtask

    initial begin
        rst_i   = 1'b1;
        cfg_a_i = 24'h0F_0000;
        cfg_b_i = 24'h10_5555;
        cfg_c_i = 24'hFF_FFFF;
        cfg_d_i = 24'h00_0001;
        repeat (3) @(negedge clk_i);
        check_eq("reset pwm", int'(pwm_o), 0);
        check_eq("reset frame", int'(frame_o), 0);
        rst_i = 1'b0;

        run_frame("f1", 24'h0F_0000, 24'h10_5555, 24'hFF_FFFF, 24'h00_0001,
                  -1, 0, 24'h0F_0000, 24'h10_5555, 24'hFF_FFFF, 24'h00_0001, tot_b);
`ifdef PWM_DITHER_EN
        check_eq("f1 B total", tot_b, 264);
`else
        check_eq("f1 B total", tot_b, 256);
`endif

        // Mid-frame change must wait for the next frame edge.
        run_frame("f2", 24'h0F_0000, 24'h10_5555, 24'hFF_FFFF, 24'h00_0001,
                  5, 50, 24'h4E_0000, 24'h10_5555, 24'hFF_FFFF, 24'h00_0000, tot_b);
        // Change on the last output cycle lands exactly on the load edge.
        run_frame("f3", 24'h4E_0000, 24'h10_5555, 24'hFF_FFFF, 24'h00_0000,
                  15, 155, 24'h4E_0000, 24'h20_AAAA, 24'hFF_FFFF, 24'h00_0000, tot_b);
        run_frame("f4", 24'h4E_0000, 24'h20_AAAA, 24'hFF_FFFF, 24'h00_0000,
                  -1, 0, 24'h4E_0000, 24'h20_AAAA, 24'hFF_FFFF, 24'h00_0000, tot_b);

        // Frame 5: new inputs after the load edge, then reset in period 7.
        @(negedge clk_i);
        check_eq("f5 frame_o", int'(frame_o), 1);
        cfg_a_i = 24'h9C_0000;
        cfg_b_i = 24'h9C_0000;
        cfg_c_i = 24'h9C_0000;
        cfg_d_i = 24'h9C_0000;
        repeat (7 * CCRE + 20) @(negedge clk_i);
        check_eq("pre-reset pwm", int'(pwm_o), 7);
        #2 rst_i = 1'b1;
        #1;
        check_eq("async reset pwm", int'(pwm_o), 0);
        check_eq("async reset frame", int'(frame_o), 0);
        repeat (3) begin
            @(negedge clk_i);
            check_eq("held reset frame", int'(frame_o), 0);
            check_eq("held reset pwm", int'(pwm_o), 0);
        end
        rst_i = 1'b0;
        run_frame("post-rst", 24'h9C_0000, 24'h9C_0000, 24'h9C_0000, 24'h9C_0000,
                  -1, 0, 24'h9C_0000, 24'h9C_0000, 24'h9C_0000, 24'h9C_0000, tot_b);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
